// File: rtl/sdram_ringbuf.sv
// sdram_ringbuf
// Uses a region of SDRAM as a FIFO ring buffer between a 16-bit capture
// stream (s_*) and a 16-bit readout stream (m_*). Samples are written to
// BASE+wr_ptr and read back from BASE+rd_ptr through the controller's
// request channel (avalid/aready/awe/aaddr/adata). Read data comes back on
// the response channel (bvalid/bwe/bdata) in request order. It is parked in
// a small on-chip show-ahead FIFO until the readout consumer takes it.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   s_valid/s_ready/s_data   sample input stream
//   m_valid/m_ready/m_data   readout stream
//   flush, flush_done        discard request and its completion pulse
//   fill                     words in the ring not yet read-requested
//   resp_err                 sticky: read data arrived with nothing outstanding
//   avalid/aready/awe/aaddr/adata   request channel to the SDRAM controller
//   bvalid/bwe/bdata                response channel from the controller
module sdram_ringbuf #(
  parameter int unsigned ADDR_W     = 24,
  parameter logic [23:0] BASE       = 24'h000000,
  parameter int unsigned RFIFO_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [15:0]       s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [15:0]       m_data,
  input  logic              flush,
  output logic              flush_done,
  output logic [ADDR_W:0]   fill,
  output logic              resp_err,
  output logic              avalid,
  input  logic              aready,
  output logic              awe,
  output logic [23:0]       aaddr,
  output logic [15:0]       adata,
  input  logic              bvalid,
  input  logic              bwe,
  input  logic [15:0]       bdata
);

  localparam int unsigned   RD   = 1 << RFIFO_LOG2;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(1) << ADDR_W;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0]       rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]         fill_q, fill_d;
  logic [RFIFO_LOG2:0]     outst_q, outst_d;
  logic                    lastRd_q, lastRd_d;
  logic                    flushPend_q, flushPend_d;
  logic                    respErr_q, respErr_d;
  logic                    awe_q, awe_d;
  logic [23:0]             aaddr_q, aaddr_d;
  logic [15:0]             adata_q, adata_d;
  logic [RFIFO_LOG2-1:0]   rfHead_q, rfHead_d;
  logic [RFIFO_LOG2-1:0]   rfTail_q, rfTail_d;
  logic [RFIFO_LOG2:0]     rfCount_q, rfCount_d;
  logic [15:0]             rfMem [RD];

  logic                    idle;
  logic                    wrElig;
  logic                    rdElig;
  logic [RFIFO_LOG2+1:0]   credUsed;
  logic                    wrFire;
  logic                    rdFire;
  logic                    rspRead;
  logic                    rspPush;
  logic                    rspStray;
  logic                    rfPop;
  logic                    flushClear;

  // Issue eligibility. Read credits count both reads in flight and words
  // already parked on chip, so every returning word is guaranteed a slot.
  always_comb begin
    idle       = (state_q == IDLE);
    credUsed   = (RFIFO_LOG2+2)'(outst_q) + (RFIFO_LOG2+2)'(rfCount_q);
    wrElig     = (fill_q != FULL) && !flushPend_q;
    rdElig     = (fill_q != '0) && (credUsed < (RFIFO_LOG2+2)'(RD)) && !flushPend_q;
    // A write only wins when no read is eligible or the last issue was a read.
    s_ready    = idle && wrElig && !(rdElig && !lastRd_q) && !rst;
    wrFire     = s_valid && s_ready;
    rdFire     = idle && rdElig && !wrFire;
    rspRead    = bvalid && !bwe;
    rspPush    = rspRead && (outst_q != '0);
    rspStray   = rspRead && (outst_q == '0);
    rfPop      = m_valid && m_ready;
    flushClear = idle && flushPend_q && (outst_q == '0);
  end

  // Next-state logic: request FSM, ring pointers, credits and read FIFO.
  always_comb begin
    state_d     = state_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    fill_d      = fill_q;
    outst_d     = outst_q;
    lastRd_d    = lastRd_q;
    awe_d       = awe_q;
    aaddr_d     = aaddr_q;
    adata_d     = adata_q;
    rfHead_d    = rfHead_q;
    rfTail_d    = rfTail_q;
    rfCount_d   = rfCount_q;
    respErr_d   = respErr_q | rspStray;
    flushPend_d = (flushPend_q && !flushClear) || flush;

    case (state_q)
      IDLE: begin
        if (wrFire) begin
          state_d  = REQ;
          awe_d    = 1'b1;
          aaddr_d  = BASE + 24'(wrPtr_q);
          adata_d  = s_data;
          wrPtr_d  = wrPtr_q + ADDR_W'(1);
          fill_d   = fill_q + (ADDR_W+1)'(1);
          lastRd_d = 1'b0;
        end else if (rdFire) begin
          state_d  = REQ;
          awe_d    = 1'b0;
          aaddr_d  = BASE + 24'(rdPtr_q);
          rdPtr_d  = rdPtr_q + ADDR_W'(1);
          fill_d   = fill_q - (ADDR_W+1)'(1);
          lastRd_d = 1'b1;
        end
      end
      REQ: begin
        if (aready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Issue and return in the same cycle cancel out.
    case ({rdFire, rspPush})
      2'b10:   outst_d = outst_q + (RFIFO_LOG2+1)'(1);
      2'b01:   outst_d = outst_q - (RFIFO_LOG2+1)'(1);
      default: outst_d = outst_q;
    endcase

    if (rspPush) begin
      rfTail_d = rfTail_q + RFIFO_LOG2'(1);
    end
    if (rfPop) begin
      rfHead_d = rfHead_q + RFIFO_LOG2'(1);
    end
    case ({rspPush, rfPop})
      2'b10:   rfCount_d = rfCount_q + (RFIFO_LOG2+1)'(1);
      2'b01:   rfCount_d = rfCount_q - (RFIFO_LOG2+1)'(1);
      default: rfCount_d = rfCount_q;
    endcase

    // Flush completes only once the controller owes us nothing; any words
    // that landed in the read FIFO meanwhile are thrown away here.
    if (flushClear) begin
      wrPtr_d   = '0;
      rdPtr_d   = '0;
      fill_d    = '0;
      rfHead_d  = '0;
      rfTail_d  = '0;
      rfCount_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fill_q      <= '0;
      outst_q     <= '0;
      lastRd_q    <= 1'b0;
      flushPend_q <= 1'b0;
      respErr_q   <= 1'b0;
      awe_q       <= 1'b0;
      aaddr_q     <= '0;
      adata_q     <= '0;
      rfHead_q    <= '0;
      rfTail_q    <= '0;
      rfCount_q   <= '0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fill_q      <= fill_d;
      outst_q     <= outst_d;
      lastRd_q    <= lastRd_d;
      flushPend_q <= flushPend_d;
      respErr_q   <= respErr_d;
      awe_q       <= awe_d;
      aaddr_q     <= aaddr_d;
      adata_q     <= adata_d;
      rfHead_q    <= rfHead_d;
      rfTail_q    <= rfTail_d;
      rfCount_q   <= rfCount_d;
    end
  end

  // Read FIFO storage; validity is tracked by rfCount_q so no reset needed.
  always_ff @(posedge clk) begin
    if (rspPush) begin
      rfMem[rfTail_q] <= bdata;
    end
  end

  always_comb begin
    avalid     = (state_q == REQ);
    awe        = awe_q;
    aaddr      = aaddr_q;
    adata      = adata_q;
    fill       = fill_q;
    resp_err   = respErr_q;
    flush_done = flushClear;
    m_valid    = (rfCount_q != '0);
    m_data     = m_valid ? rfMem[rfHead_q] : 16'h0000;
  end

endmodule
